// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchronizer, mid-bit sampling baud timer, valid/ready output
// with one-cycle framing and overrun error pulses.
module uart_receiver #(
    parameter int unsigned CLK_HZ    = 25_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int unsigned DIVISOR = CLK_HZ / BAUD_RATE;
    localparam int unsigned CW      = $clog2(DIVISOR) + 1;
    localparam int unsigned BW      = $clog2(DATA_BITS + 1);

    // Loading N gives a sample N+1 cycles later.
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 sample;

    assign sample = (baud_cnt == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            state         <= StIdle;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            rx_meta       <= rx;
            rx_s          <= rx_meta;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;

            // A load in the stop state below overrides this clear.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (!rx_s) begin
                        baud_cnt <= HALF_LOAD;
                        busy     <= 1'b1;
                        state    <= StStart;
                    end
                end
                StStart: begin
                    if (sample) begin
                        baud_cnt <= FULL_LOAD;
                        if (rx_s) begin
                            busy  <= 1'b0;
                            state <= StIdle;
                        end else begin
                            bit_cnt <= '0;
                            state   <= StData;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                StData: begin
                    if (sample) begin
                        baud_cnt <= FULL_LOAD;
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= StStop;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                StStop: begin
                    if (sample) begin
                        if (rx_s) begin
                            busy  <= 1'b0;
                            state <= StIdle;
                            if (!data_valid || data_ready) begin
                                data       <= shreg;
                                data_valid <= 1'b1;
                            end else begin
                                overrun_error <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                            state         <= StBreak;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
